hog_bus_reader: RTL and testbench

HOG_BUS_READER -- requirements
Module: hog_bus_reader

---
 rtl/hog_bus_pkg.sv | 19 +
 rtl/hog_bus_reader.sv | 131 +++++++++++++
 tb/tb_hog_bus_reader.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hog_bus_pkg.sv
// hog_bus_pkg: reader state encoding and descriptor meta layout,
// shared between the HOG bus reader and its responder.
package hog_bus_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_PUSH,
      S_CLR_REQ,
      S_CLR_GAP,
      S_ERR
   } state_t;

   localparam int META_W     = 3;
   localparam int META_VALID = 0;
   localparam int META_SOP   = 1;
   localparam int META_EOP   = 2;

endpackage

// File: rtl/hog_bus_reader.sv
// hog_bus_reader: drains the HOG descriptor FIFO over ext_bus on irq,
// streams descriptors out, then clears the responder irq.
module hog_bus_reader
   import hog_bus_pkg::*;
#(
   parameter int ADDR_WIDTH   = 5,
   parameter int BUS_WIDTH    = 128,
   parameter int DATA_ADDR    = 0,
   parameter int IRQ_CLR_ADDR = 1,
   parameter int TIMEOUT      = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    irq,
   output logic [ADDR_WIDTH-1:0]   addr,
   output logic                    bus_enable,
   output logic                    r_wbar,
   output logic [BUS_WIDTH/8-1:0]  byte_enable,
   output logic [BUS_WIDTH-1:0]    write_data,
   input  logic                    ack,
   input  logic [BUS_WIDTH-1:0]    read_data,
   output logic [BUS_WIDTH-4:0]    out_data,
   output logic                    out_sop,
   output logic                    out_eop,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             words_read,
   output logic                    timeout_err
);

   localparam int PAY_W = BUS_WIDTH - META_W;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t state, state_nx;

   logic [15:0]       to_cnt;
   logic [META_W-1:0] meta;
   logic              req_st;
   logic              ack_ok;
   logic              timed_out;
   logic              bus_en_d;

   assign meta   = read_data[BUS_WIDTH-1 -: META_W];
   assign req_st = (state == S_RD_REQ) || (state == S_CLR_REQ);

   // An ack only counts while a request is actually on the bus.
   assign ack_ok    = ack && bus_enable && req_st;
   assign timed_out = bus_enable && req_st && !ack
                      && (to_cnt == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (enable && irq) state_nx = S_RD_REQ;
         S_RD_REQ:
            if (ack_ok)
               state_nx = meta[META_VALID] ? S_PUSH : S_CLR_REQ;
            else if (timed_out)
               state_nx = S_ERR;
         S_PUSH:
            if (out_ready) state_nx = S_RD_REQ;
         S_CLR_REQ:
            if (ack_ok)         state_nx = S_CLR_GAP;
            else if (timed_out) state_nx = S_ERR;
         S_CLR_GAP:
            state_nx = S_IDLE;
         S_ERR:
            if (!enable) state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   // Request drops for the cycle after any ack, forcing a bus idle gap.
   always_comb begin
      bus_en_d = 1'b0;
      if ((state_nx == S_RD_REQ || state_nx == S_CLR_REQ) && !ack_ok)
         bus_en_d = 1'b1;
   end

   assign out_valid   = (state == S_PUSH);
   assign byte_enable = '1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_enable  <= 1'b0;
         r_wbar      <= 1'b1;
         addr        <= '0;
         write_data  <= '0;
         to_cnt      <= '0;
         out_data    <= '0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         words_read  <= '0;
         timeout_err <= 1'b0;
      end else begin
         bus_enable <= bus_en_d;

         if (state_nx == S_RD_REQ) begin
            addr       <= ADDR_WIDTH'(DATA_ADDR);
            r_wbar     <= 1'b1;
            write_data <= '0;
         end else if (state_nx == S_CLR_REQ) begin
            addr       <= ADDR_WIDTH'(IRQ_CLR_ADDR);
            r_wbar     <= 1'b0;
            write_data <= BUS_WIDTH'(1);
         end

         if (bus_enable && req_st && !ack_ok) to_cnt <= to_cnt + 16'd1;
         else                                 to_cnt <= '0;

         if (state == S_RD_REQ && ack_ok) begin
            out_data <= read_data[PAY_W-1:0];
            out_sop  <= meta[META_SOP];
            out_eop  <= meta[META_EOP];
         end

         if (out_valid && out_ready) words_read <= words_read + 16'd1;

         if (timed_out) timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hog_bus_reader.sv
// tb_hog_bus_reader: directed scenarios against a cycle-stepped
// responder model for hog_bus_reader.
module tb_hog_bus_reader;

   localparam logic [124:0] P1 = 125'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [124:0] P2 = 125'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [124:0] P3 = 125'h1FFF_0000_FFFF_0000_A5A5_5A5A_C3C3_3C3C;
   localparam logic [124:0] P4 = 125'h1BAD_CAFE_0000_1234_DEAD_BEEF_5555_AAAA;
   localparam logic [124:0] P5 = 125'h0000_0000_0000_0000_0000_0000_0000_0001;
   localparam logic [124:0] P6 = 125'h1000_0000_0000_0000_0000_0000_0000_0000;
   localparam logic [124:0] P7 = 125'h0F0F_0F0F_F0F0_F0F0_1357_9BDF_2468_ACE0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic         irq = 1'b0;
   logic [4:0]   addr;
   logic         bus_enable;
   logic         r_wbar;
   logic [15:0]  byte_enable;
   logic [127:0] write_data;
   logic         ack = 1'b0;
   logic [127:0] read_data = '0;
   logic [124:0] out_data;
   logic         out_sop;
   logic         out_eop;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [15:0]  words_read;
   logic         timeout_err;

   int errs = 0;
   int checks = 0;

   // Responder model state
   logic [127:0] rd_q[$];
   logic [4:0]   wr_addr[$];
   logic [127:0] wr_data[$];
   logic [124:0] bt_data[$];
   logic         bt_sop[$];
   logic         bt_eop[$];
   int  delay = 0;
   bit  no_ack = 1'b0;
   int  resp_cnt = 0;
   bit  prev_ack = 1'b0;
   int  run = 0;
   int  max_run = 0;
   int  be_err = 0;
   int  gap_err = 0;

   always #5 clk = ~clk;

   hog_bus_reader dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .irq         (irq),
      .addr        (addr),
      .bus_enable  (bus_enable),
      .r_wbar      (r_wbar),
      .byte_enable (byte_enable),
      .write_data  (write_data),
      .ack         (ack),
      .read_data   (read_data),
      .out_data    (out_data),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .words_read  (words_read),
      .timeout_err (timeout_err)
   );

   function automatic logic [127:0] mk(input logic [2:0] m,
                                       input logic [124:0] p);
      return {m, p};
   endfunction

   // One clock: observe the pre-edge values, answer the bus, advance.
   task automatic step();
      if (byte_enable !== 16'hFFFF) be_err++;
      if (prev_ack && bus_enable) gap_err++;
      if (bus_enable) run++;
      else            run = 0;
      if (run > max_run) max_run = run;
      if (out_valid && out_ready) begin
         bt_data.push_back(out_data);
         bt_sop.push_back(out_sop);
         bt_eop.push_back(out_eop);
      end
      read_data = '0;
      if (rst) begin
         ack = 1'b0;
         resp_cnt = 0;
      end else if (bus_enable) begin
         if (!no_ack && resp_cnt == delay) begin
            ack = 1'b1;
            resp_cnt = 0;
            if (r_wbar) begin
               if (rd_q.size() > 0) read_data = rd_q.pop_front();
            end else begin
               wr_addr.push_back(addr);
               wr_data.push_back(write_data);
            end
         end else begin
            ack = 1'b0;
            resp_cnt++;
         end
      end else begin
         ack = 1'b0;
         resp_cnt = 0;
      end
      prev_ack = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wr_addr.delete();
      wr_data.delete();
      bt_data.delete();
      bt_sop.delete();
      bt_eop.delete();
      max_run = 0;
   endtask

   task automatic run_until_wr(input int limit, input string name);
      for (int i = 0; i < limit && wr_addr.size() == 0; i++) step();
      checks++;
      if (wr_addr.size() == 0) begin
         errs++;
         $display("FAIL %s: no irq-clear write within %0d cycles", name, limit);
      end
      irq = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks += 10;
      if (bus_enable !== 1'b0) begin errs++;
         $display("FAIL rst_bus_enable got=%b want=0", bus_enable); end
      if (r_wbar !== 1'b1) begin errs++;
         $display("FAIL rst_r_wbar got=%b want=1", r_wbar); end
      if (addr !== 5'd0) begin errs++;
         $display("FAIL rst_addr got=%0d want=0", addr); end
      if (write_data !== 128'd0) begin errs++;
         $display("FAIL rst_write_data got=%h want=0", write_data); end
      if (byte_enable !== 16'hFFFF) begin errs++;
         $display("FAIL rst_byte_enable got=%h want=ffff", byte_enable); end
      if (out_valid !== 1'b0) begin errs++;
         $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      if (out_data !== 125'd0) begin errs++;
         $display("FAIL rst_out_data got=%h want=0", out_data); end
      if ({out_sop, out_eop} !== 2'b00) begin errs++;
         $display("FAIL rst_sop_eop got=%b want=00", {out_sop, out_eop}); end
      if (words_read !== 16'd0) begin errs++;
         $display("FAIL rst_words_read got=%0d want=0", words_read); end
      if (timeout_err !== 1'b0) begin errs++;
         $display("FAIL rst_timeout_err got=%b want=0", timeout_err); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_stream();
      clear_logs();
      rd_q = '{mk(3'b011, P1), mk(3'b001, P2), mk(3'b101, P3), mk(3'b000, '0)};
      delay = 0;
      out_ready = 1'b1;
      enable = 1'b1;
      irq = 1'b1;
      run_until_wr(200, "stream");
      checks++;
      if (bt_data.size() != 3) begin
         errs++;
         $display("FAIL stream_beats got=%0d want=3", bt_data.size());
      end else begin
         checks += 6;
         if (bt_data[0] !== P1) begin errs++;
            $display("FAIL stream_d0 got=%h want=%h", bt_data[0], P1); end
         if (bt_data[1] !== P2) begin errs++;
            $display("FAIL stream_d1 got=%h want=%h", bt_data[1], P2); end
         if (bt_data[2] !== P3) begin errs++;
            $display("FAIL stream_d2 got=%h want=%h", bt_data[2], P3); end
         if ({bt_sop[0], bt_eop[0]} !== 2'b10) begin errs++;
            $display("FAIL stream_se0 got=%b want=10", {bt_sop[0], bt_eop[0]}); end
         if ({bt_sop[1], bt_eop[1]} !== 2'b00) begin errs++;
            $display("FAIL stream_se1 got=%b want=00", {bt_sop[1], bt_eop[1]}); end
         if ({bt_sop[2], bt_eop[2]} !== 2'b01) begin errs++;
            $display("FAIL stream_se2 got=%b want=01", {bt_sop[2], bt_eop[2]}); end
      end
      checks += 2;
      if (words_read !== 16'd3) begin errs++;
         $display("FAIL stream_words got=%0d want=3", words_read); end
      if (wr_addr.size() != 1) begin errs++;
         $display("FAIL stream_writes got=%0d want=1", wr_addr.size());
      end else begin
         checks += 2;
         if (wr_addr[0] !== 5'd1) begin errs++;
            $display("FAIL stream_wr_addr got=%0d want=1", wr_addr[0]); end
         if (wr_data[0] !== 128'd1) begin errs++;
            $display("FAIL stream_wr_data got=%h want=1", wr_data[0]); end
      end
   endtask

   task automatic test_backpressure();
      clear_logs();
      rd_q = '{mk(3'b111, P4), mk(3'b000, '0)};
      out_ready = 1'b0;
      irq = 1'b1;
      for (int i = 0; i < 50 && !out_valid; i++) step();
      checks++;
      if (!out_valid) begin errs++;
         $display("FAIL bp_reach_push got=0 want=1"); end
      for (int i = 0; i < 10; i++) begin
         step();
         checks += 3;
         if (out_valid !== 1'b1) begin errs++;
            $display("FAIL bp_valid c%0d got=%b want=1", i, out_valid); end
         if (out_data !== P4) begin errs++;
            $display("FAIL bp_data c%0d got=%h want=%h", i, out_data, P4); end
         if (bus_enable !== 1'b0) begin errs++;
            $display("FAIL bp_bus c%0d got=%b want=0", i, bus_enable); end
      end
      out_ready = 1'b1;
      run_until_wr(200, "bp");
      checks += 3;
      if (words_read !== 16'd4) begin errs++;
         $display("FAIL bp_words got=%0d want=4", words_read); end
      if (bt_data.size() != 1) begin errs++;
         $display("FAIL bp_beats got=%0d want=1", bt_data.size());
      end else if ({bt_sop[0], bt_eop[0]} !== 2'b11) begin errs++;
         $display("FAIL bp_se got=%b want=11", {bt_sop[0], bt_eop[0]});
      end
   endtask

   task automatic test_ack_at_limit();
      clear_logs();
      rd_q = '{mk(3'b001, P6), mk(3'b000, '0)};
      delay = 254;
      irq = 1'b1;
      run_until_wr(1200, "limit");
      delay = 0;
      checks += 4;
      if (timeout_err !== 1'b0) begin errs++;
         $display("FAIL limit_err got=%b want=0", timeout_err); end
      if (max_run != 255) begin errs++;
         $display("FAIL limit_run got=%0d want=255", max_run); end
      if (words_read !== 16'd5) begin errs++;
         $display("FAIL limit_words got=%0d want=5", words_read); end
      if (bt_data.size() != 1 || bt_data[0] !== P6) begin errs++;
         $display("FAIL limit_beat got_n=%0d want=1 beat P6", bt_data.size());
      end
   endtask

   task automatic test_timeout();
      bit seen_hi;
      clear_logs();
      no_ack = 1'b1;
      irq = 1'b1;
      for (int i = 0; i < 400 && !timeout_err; i++) step();
      checks += 3;
      if (timeout_err !== 1'b1) begin errs++;
         $display("FAIL to_flag got=%b want=1", timeout_err); end
      if (max_run != 255) begin errs++;
         $display("FAIL to_run got=%0d want=255", max_run); end
      if (bus_enable !== 1'b0) begin errs++;
         $display("FAIL to_bus got=%b want=0", bus_enable); end
      seen_hi = 1'b0;
      repeat (5) begin
         step();
         if (bus_enable) seen_hi = 1'b1;
      end
      checks++;
      if (seen_hi !== 1'b0) begin errs++;
         $display("FAIL to_err_hold got=%b want=0", seen_hi); end
      enable = 1'b0;
      irq = 1'b0;
      no_ack = 1'b0;
      repeat (2) step();
      clear_logs();
      rd_q = '{mk(3'b001, P5), mk(3'b000, '0)};
      enable = 1'b1;
      irq = 1'b1;
      run_until_wr(200, "to_restart");
      checks += 3;
      if (timeout_err !== 1'b1) begin errs++;
         $display("FAIL to_sticky got=%b want=1", timeout_err); end
      if (words_read !== 16'd6) begin errs++;
         $display("FAIL to_words got=%0d want=6", words_read); end
      if (bt_data.size() != 1 || bt_data[0] !== P5) begin errs++;
         $display("FAIL to_beat got_n=%0d want=1 beat P5", bt_data.size());
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      delay = 1000;
      irq = 1'b1;
      for (int i = 0; i < 50 && !bus_enable; i++) step();
      checks++;
      if (!bus_enable) begin errs++;
         $display("FAIL rm_bus_req got=0 want=1"); end
      step();
      #2 rst = 1'b1;
      #1;
      checks += 5;
      if (bus_enable !== 1'b0) begin errs++;
         $display("FAIL rm_bus got=%b want=0", bus_enable); end
      if (out_valid !== 1'b0) begin errs++;
         $display("FAIL rm_valid got=%b want=0", out_valid); end
      if (words_read !== 16'd0) begin errs++;
         $display("FAIL rm_words got=%0d want=0", words_read); end
      if (timeout_err !== 1'b0) begin errs++;
         $display("FAIL rm_err got=%b want=0", timeout_err); end
      if ({r_wbar, addr} !== 6'b1_00000) begin errs++;
         $display("FAIL rm_rw_addr got=%b want=100000", {r_wbar, addr}); end
      ack = 1'b0;
      prev_ack = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      delay = 0;
      rd_q = '{mk(3'b101, P7), mk(3'b000, '0)};
      run_until_wr(200, "rm_restart");
      checks += 2;
      if (words_read !== 16'd1) begin errs++;
         $display("FAIL rm_words2 got=%0d want=1", words_read); end
      if (bt_data.size() != 1 || bt_data[0] !== P7) begin errs++;
         $display("FAIL rm_beat got_n=%0d want=1 beat P7", bt_data.size());
      end
   endtask

   task automatic test_bus_rules();
      checks += 2;
      if (gap_err != 0) begin errs++;
         $display("FAIL bus_gap got=%0d want=0", gap_err); end
      if (be_err != 0) begin errs++;
         $display("FAIL byte_enable got=%0d want=0", be_err); end
   endtask

   initial begin
      #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_ack_at_limit();
      test_timeout();
      test_reset_mid();
      test_bus_rules();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
